block_scatter_buffer: RTL and testbench
=======================================

BLOCK_SCATTER_BUFFER -- requirements
Module: block_scatter_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bit width of one coefficient word.
REQ-002 SHALL have parameter BLK_DIM, default 8, block edge length; block holds BLK_DIM*BLK_DIM words.
REQ-003 SHALL have parameter MAX_BLOCKS, default 32, buffer depth in blocks; memory depth MAX_BLOCKS*BLK_DIM*BLK_DIM words.
REQ-004 SHALL have ports: clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports: num_blocks  input  $clog2(MAX_BLOCKS)+1  blocks per frame.
REQ-007 SHALL have ports: transpose  input  1  0 = row-major store, 1 = column-major store.
REQ-008 SHALL have ports: in_valid  input  1; in_ready  output  1  block handshake.
REQ-009 SHALL have ports: in_block  input  BLK_DIM*BLK_DIM*DATA_W  block, element [r][c] at word index r*BLK_DIM+c.
REQ-010 SHALL have ports: out_valid  input/output pair: out_valid output 1, out_ready input 1  word-stream handshake.
REQ-011 SHALL have ports: out_data  output  DATA_W; out_last  output  1  final word of frame.
REQ-012 SHALL have ports: block_count  output  $clog2(MAX_BLOCKS)+1  blocks stored in current frame.

Function
REQ-013 SHALL implement states FILL, WRITE, DRAIN; FILL after reset.
REQ-014 SHALL drive in_ready = 1 only in FILL; out_valid = 1 only in DRAIN.
REQ-015 SHALL, in FILL on in_valid && in_ready, capture in_block and transpose into a holding register, set row index 0, go to WRITE.
REQ-016 SHALL sample num_blocks and transpose only on the first block accepted in a frame (block_count == 0); later changes ignored until next frame.
REQ-017 SHALL treat sampled num_blocks == 0 or > MAX_BLOCKS as MAX_BLOCKS.
REQ-018 SHALL, in WRITE, write one row of BLK_DIM words per cycle at address block_count*BLK_DIM^2 + row*BLK_DIM + c; transpose = 1 stores element [r][c] at address ... + c*BLK_DIM + r.
REQ-019 SHALL, on the cycle writing row BLK_DIM-1, increment block_count and go to DRAIN if new block_count equals sampled num_blocks, else FILL.
REQ-020 SHALL therefore reassert in_ready exactly BLK_DIM+1 cycles after an accepting edge (max one block per BLK_DIM+1 cycles).
REQ-021 SHALL, in DRAIN, present out_data = memory[rd_ptr] combinationally, rd_ptr starting at 0, advancing by 1 on each out_valid && out_ready.
REQ-022 SHALL assert out_last when rd_ptr == num_blocks*BLK_DIM^2 - 1.
REQ-023 SHALL hold out_data/out_last stable while out_valid && !out_ready.
REQ-024 SHALL, on handshake with out_last, clear rd_ptr and block_count and return to FILL next cycle.
REQ-025 SHALL drive out_data = 0 and out_last = 0 whenever out_valid = 0.
REQ-026 SHALL never write memory outside WRITE; in_valid outside FILL is ignored (no acceptance).

Reset
REQ-027 SHALL, with reset high at a rising edge, enter FILL and clear block_count, rd_ptr, row index, sampled config; outputs in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, block_count = 0 from the following cycle.
REQ-028 SHALL abandon any partial WRITE or DRAIN on reset; memory contents need not be cleared, partially written data is discarded by count reset.
REQ-029 SHALL give reset priority over every simultaneous handshake.

Verification
REQ-030 Defaults, num_blocks=1, transpose=0, block word r*8+c = 100*r+c -> in_ready low 8 cycles, DRAIN streams 64 words 0,1,...,7,100,...,707; out_last on word 64.
REQ-031 transpose=1, same block -> stream order 0,100,...,700,1,101,...; block_count = 1 during DRAIN.
REQ-032 num_blocks=3, block k filled with k*1000+index, in_valid held high -> acceptances 9 cycles apart; 192 words; word 64 = 1000; out_last at word 192.
REQ-033 num_blocks=0 -> frame closes only after 32 blocks; block_count reads 32 in DRAIN; 2048 words, out_last on last.
REQ-034 Random out_ready stalls in DRAIN -> out_data stable while stalled, no word lost or duplicated; in_ready = 0 throughout DRAIN.
REQ-035 reset pulsed during WRITE row 4, then one block of value 7 with num_blocks=1 -> all 64 streamed words equal 7, block_count sequence 0 -> 1.

Source files
------------

// File: rtl/block_scatter_buffer.sv
// Block scatter buffer: collects BLK_DIM x BLK_DIM coefficient blocks into a frame memory
// (row-major or transposed), then streams the whole frame out one word per handshake.
module block_scatter_buffer #(
    parameter int DATA_W     = 32,
    parameter int BLK_DIM    = 8,
    parameter int MAX_BLOCKS = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [$clog2(MAX_BLOCKS):0]       num_blocks,
    input  logic                              transpose,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BLK_DIM*BLK_DIM*DATA_W-1:0] in_block,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_last,
    output logic [$clog2(MAX_BLOCKS):0]       block_count
);
    localparam int CNT_W     = $clog2(MAX_BLOCKS) + 1;
    localparam int BLK_WORDS = BLK_DIM * BLK_DIM;
    localparam int BLK_BITS  = BLK_WORDS * DATA_W;
    localparam int ROW_BITS  = BLK_DIM * DATA_W;
    localparam int MEM_ROWS  = MAX_BLOCKS * BLK_DIM;
    localparam int MEM_WORDS = MAX_BLOCKS * BLK_WORDS;
    localparam int ROW_W     = (BLK_DIM > 1) ? $clog2(BLK_DIM) : 1;
    localparam int RA_W      = (MEM_ROWS > 1) ? $clog2(MEM_ROWS) : 1;
    localparam int RD_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    block_count_q, block_count_d;
    logic [RD_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    cfg_nblk_q, cfg_nblk_d;
    logic                cfg_tr_q, cfg_tr_d;
    logic [BLK_BITS-1:0] hold_q, hold_d;

    // One memory row holds one block row, so a whole row lands in a single write.
    logic [ROW_BITS-1:0] mem [MEM_ROWS];

    logic [CNT_W-1:0]    nblk_eff;
    logic [CNT_W-1:0]    blk_inc;
    logic                first_blk;
    logic                tr_sel;
    logic                mem_we;
    logic                last_hit;
    logic [BLK_BITS-1:0] blk_xpose;
    logic [RA_W-1:0]     wr_row;
    logic [RA_W-1:0]     rd_row;
    logic [ROW_W-1:0]    rd_col;
    logic [DATA_W-1:0]   rd_word;
    logic [RD_W:0]       frame_last;

    always_comb begin
        nblk_eff = num_blocks;
        if (num_blocks == '0 || num_blocks > CNT_W'(MAX_BLOCKS)) begin
            nblk_eff = CNT_W'(MAX_BLOCKS);
        end
    end

    assign first_blk = (block_count_q == '0);
    assign tr_sel    = first_blk ? transpose : cfg_tr_q;
    assign blk_inc   = block_count_q + CNT_W'(1);

    // Transposing on capture lets every WRITE cycle store one contiguous memory row.
    always_comb begin
        blk_xpose = '0;
        for (int r = 0; r < BLK_DIM; r++) begin
            for (int c = 0; c < BLK_DIM; c++) begin
                blk_xpose[(r*BLK_DIM+c)*DATA_W +: DATA_W] = in_block[(c*BLK_DIM+r)*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_row     = RA_W'(block_count_q) * RA_W'(BLK_DIM) + RA_W'(row_q);
    assign rd_row     = RA_W'(rd_ptr_q / RD_W'(BLK_DIM));
    assign rd_col     = ROW_W'(rd_ptr_q % RD_W'(BLK_DIM));
    assign rd_word    = mem[rd_row][int'(rd_col)*DATA_W +: DATA_W];
    assign frame_last = (RD_W+1)'(cfg_nblk_q) * (RD_W+1)'(BLK_WORDS) - (RD_W+1)'(1);
    assign last_hit   = ({1'b0, rd_ptr_q} == frame_last);

    always_comb begin
        state_d       = state_q;
        block_count_d = block_count_q;
        rd_ptr_d      = rd_ptr_q;
        row_d         = row_q;
        cfg_nblk_d    = cfg_nblk_q;
        cfg_tr_d      = cfg_tr_q;
        hold_d        = hold_q;
        mem_we        = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    hold_d  = tr_sel ? blk_xpose : in_block;
                    row_d   = '0;
                    state_d = WRITE;
                    if (first_blk) begin
                        cfg_nblk_d = nblk_eff;
                        cfg_tr_d   = transpose;
                    end
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                row_d  = row_q + 1'b1;
                if (row_q == ROW_W'(BLK_DIM - 1)) begin
                    row_d         = '0;
                    block_count_d = blk_inc;
                    state_d       = (blk_inc == cfg_nblk_q) ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (last_hit) begin
                        rd_ptr_d      = '0;
                        block_count_d = '0;
                        state_d       = FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FILL;
            block_count_q <= '0;
            rd_ptr_q      <= '0;
            row_q         <= '0;
            cfg_nblk_q    <= '0;
            cfg_tr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            block_count_q <= block_count_d;
            rd_ptr_q      <= rd_ptr_d;
            row_q         <= row_d;
            cfg_nblk_q    <= cfg_nblk_d;
            cfg_tr_q      <= cfg_tr_d;
        end
    end

    // Data path carries no reset; a write cut short by reset is discarded by the count reset.
    always_ff @(posedge clock) begin
        hold_q <= hold_d;
        if (mem_we && !reset) begin
            mem[wr_row] <= hold_q[int'(row_q)*ROW_BITS +: ROW_BITS];
        end
    end

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == DRAIN);
    assign out_data    = out_valid ? rd_word : '0;
    assign out_last    = out_valid && last_hit;
    assign block_count = block_count_q;

endmodule

// File: tb/tb_block_scatter_buffer.sv
// Directed bench for block_scatter_buffer: single/multi-block frames, transpose, default frame
// size, output stalls and reset mid-write, each word checked against hand-computed values.
module tb_block_scatter_buffer;
    localparam int DATA_W     = 32;
    localparam int BLK_DIM    = 8;
    localparam int MAX_BLOCKS = 32;
    localparam int BW         = BLK_DIM * BLK_DIM * DATA_W;

    logic              clock = 1'b0;
    logic              reset;
    logic [5:0]        num_blocks;
    logic              transpose;
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     in_block;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [5:0]        block_count;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int unsigned exp_q[$];

    block_scatter_buffer #(
        .DATA_W(DATA_W), .BLK_DIM(BLK_DIM), .MAX_BLOCKS(MAX_BLOCKS)
    ) dut (
        .clock(clock), .reset(reset), .num_blocks(num_blocks), .transpose(transpose),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .block_count(block_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: word r*8+c = 100*r+c; mode 1: k*1000+index; otherwise every word = k
    function automatic logic [BW-1:0] mk_block(input int mode, input int k);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < BLK_DIM*BLK_DIM; i++) begin
            int v;
            case (mode)
                0:       v = 100*(i/BLK_DIM) + (i%BLK_DIM);
                1:       v = k*1000 + i;
                default: v = k;
            endcase
            b[i*DATA_W +: DATA_W] = DATA_W'(v);
        end
        return b;
    endfunction

    task automatic send_block(input logic [BW-1:0] blk, output int acc_cyc);
        int w;
        in_block = blk;
        in_valid = 1'b1;
        w = 0;
        @(negedge clock);
        while (!in_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", w, 0);
            acc_cyc  = -1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic drain(input bit stall, input int exp_bc);
        int n, got, guard;
        logic [DATA_W-1:0] held;
        logic held_last;
        bit stalled;
        n = exp_q.size();
        got = 0; guard = 0; stalled = 0; held = '0; held_last = 1'b0;
        while (got < n && guard < 8*n + 100) begin
            @(negedge clock);
            guard++;
            if (!out_valid) begin
                chk("drain_valid", out_valid, 1);
                break;
            end
            if (stalled) begin
                chk("stall_data", out_data, held);
                chk("stall_last", out_last, held_last);
            end
            if (got == 0) chk("drain_block_count", block_count, exp_bc);
            if (stall && $urandom_range(0, 2) == 0) begin
                out_ready = 1'b0;
                stalled   = 1'b1;
                held      = out_data;
                held_last = out_last;
                chk("drain_in_ready", in_ready, 0);
            end else begin
                out_ready = 1'b1;
                stalled   = 1'b0;
                chk($sformatf("word%0d", got), out_data, exp_q[got]);
                chk($sformatf("last%0d", got), out_last, got == n-1);
                got++;
            end
        end
        chk("drain_count", got, n);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_block_count", block_count, 0);
        chk("post_data", out_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, acc2, lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
        num_blocks = 6'd1; transpose = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_block_count", block_count, 0);

        // single block, row-major
        send_block(mk_block(0, 0), acc0);
        chk("a_in_ready_write", in_ready, 0);
        chk("a_bc_write", block_count, 0);
        wait_valid(lat);
        chk("a_latency", lat, 8);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(100*(i/8) + (i%8));
        drain(1'b0, 1);

        // single block, transposed
        transpose = 1'b1;
        send_block(mk_block(0, 0), acc0);
        transpose = 1'b0;
        wait_valid(lat);
        chk("b_latency", lat, 8);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(100*(i%8) + (i/8));
        drain(1'b0, 1);

        // three blocks back to back; config changes after first block are ignored
        num_blocks = 6'd3;
        send_block(mk_block(1, 0), acc0);
        num_blocks = 6'd5;
        transpose  = 1'b1;
        send_block(mk_block(1, 1), acc1);
        chk("c_gap1", acc1 - acc0, 9);
        chk("c_out_valid_mid", out_valid, 0);
        send_block(mk_block(1, 2), acc2);
        chk("c_gap2", acc2 - acc1, 9);
        wait_valid(lat);
        chk("c_latency", lat, 8);
        exp_q.delete();
        for (int i = 0; i < 192; i++) exp_q.push_back((i/64)*1000 + (i%64));
        drain(1'b1, 3);

        // num_blocks = 0 means a full MAX_BLOCKS frame
        num_blocks = 6'd0;
        transpose  = 1'b0;
        for (int k = 0; k < 31; k++) send_block(mk_block(1, k), acc0);
        chk("d_bc_31st", block_count, 30);
        chk("d_no_drain_yet", out_valid, 0);
        send_block(mk_block(1, 31), acc1);
        chk("d_gap_last", acc1 - acc0, 9);
        wait_valid(lat);
        chk("d_latency", lat, 8);
        chk("d_block_count", block_count, 32);
        exp_q.delete();
        for (int i = 0; i < 2048; i++) exp_q.push_back((i/64)*1000 + (i%64));
        drain(1'b0, 32);

        // reset in the middle of a block write, then a fresh single-block frame
        num_blocks = 6'd1;
        send_block(mk_block(0, 0), acc0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("e_rst_in_ready", in_ready, 1);
        chk("e_rst_out_valid", out_valid, 0);
        chk("e_rst_block_count", block_count, 0);
        chk("e_rst_out_last", out_last, 0);
        send_block(mk_block(2, 7), acc0);
        chk("e_bc_write", block_count, 0);
        wait_valid(lat);
        chk("e_latency", lat, 8);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(7);
        drain(1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
